// File: rtl/simplerisc_pkg.sv
// Shared definitions for the SimpleRISC multi-cycle control path:
// opcodes, controller states, ALU one-hot bit positions and the decode record.
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [4:0] ILLEGAL_MIN = 5'b10101;

  localparam int ALU_W   = 13;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_CMP = 2;
  localparam int ALU_MUL = 3;
  localparam int ALU_DIV = 4;
  localparam int ALU_MOD = 5;
  localparam int ALU_LSL = 6;
  localparam int ALU_LSR = 7;
  localparam int ALU_ASR = 8;
  localparam int ALU_OR  = 9;
  localparam int ALU_AND = 10;
  localparam int ALU_NOT = 11;
  localparam int ALU_MOV = 12;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } stateT;

  typedef struct packed {
    logic [ALU_W-1:0] aluOp;
    logic             isImm;
    logic             isLd;
    logic             isSt;
    logic             isCall;
    logic             isRet;
    logic             isWb;
    logic             isB;
    logic             isBeq;
    logic             isBgt;
    logic             isMd;
  } decodeT;

endpackage

// File: rtl/simplerisc_decode.sv
// Pure combinational opcode decode; the controller registers its result in DECODE.
module simplerisc_decode
  import simplerisc_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  input  logic            immBit,
  output decodeT          dec,
  output logic            illegal
);

  always_comb begin
    dec       = '0;
    dec.isImm = immBit;
    illegal   = (opcode >= OP_W'(ILLEGAL_MIN));
    // legal opcodes all fit in the low five bits, so the case only needs those
    if (!illegal) begin
      case (opcode[4:0])
        OP_ADD:  begin dec.aluOp[ALU_ADD] = 1'b1; dec.isWb = 1'b1; end
        OP_SUB:  begin dec.aluOp[ALU_SUB] = 1'b1; dec.isWb = 1'b1; end
        OP_MUL:  begin dec.aluOp[ALU_MUL] = 1'b1; dec.isWb = 1'b1; dec.isMd = 1'b1; end
        OP_DIV:  begin dec.aluOp[ALU_DIV] = 1'b1; dec.isWb = 1'b1; dec.isMd = 1'b1; end
        OP_MOD:  begin dec.aluOp[ALU_MOD] = 1'b1; dec.isWb = 1'b1; dec.isMd = 1'b1; end
        OP_CMP:  dec.aluOp[ALU_CMP] = 1'b1;
        OP_AND:  begin dec.aluOp[ALU_AND] = 1'b1; dec.isWb = 1'b1; end
        OP_OR:   begin dec.aluOp[ALU_OR]  = 1'b1; dec.isWb = 1'b1; end
        OP_NOT:  begin dec.aluOp[ALU_NOT] = 1'b1; dec.isWb = 1'b1; end
        OP_MOV:  begin dec.aluOp[ALU_MOV] = 1'b1; dec.isWb = 1'b1; end
        OP_LSL:  begin dec.aluOp[ALU_LSL] = 1'b1; dec.isWb = 1'b1; end
        OP_LSR:  begin dec.aluOp[ALU_LSR] = 1'b1; dec.isWb = 1'b1; end
        OP_ASR:  begin dec.aluOp[ALU_ASR] = 1'b1; dec.isWb = 1'b1; end
        OP_LD:   begin dec.aluOp[ALU_ADD] = 1'b1; dec.isLd = 1'b1; dec.isWb = 1'b1; end
        OP_ST:   begin dec.aluOp[ALU_ADD] = 1'b1; dec.isSt = 1'b1; end
        OP_BEQ:  dec.isBeq = 1'b1;
        OP_BGT:  dec.isBgt = 1'b1;
        OP_B:    dec.isB = 1'b1;
        OP_CALL: begin dec.isCall = 1'b1; dec.isWb = 1'b1; end
        OP_RET:  dec.isRet = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/simplerisc_ctrl_fsm.sv
// Multi-cycle SimpleRISC sequencer: fetch/decode/exec/mem/wb with req/ack memories,
// mul/div/mod stall counter, branch resolution and sticky illegal-opcode trap.
//   state  | meaning
//   FETCH  | imem_req high, capture inst into ir on imem_ack
//   DECODE | register decode of ir; illegal opcode diverts to TRAP
//   EXEC   | one cycle, or MD_CYCLES for mul/div/mod
//   MEM    | dmem_req held until dmem_ack (ld/st only)
//   WB     | rf/pc write enables, branch target select
//   TRAP   | all requests off; only reset leaves
module simplerisc_ctrl_fsm
  import simplerisc_pkg::*;
#(
  parameter int INST_W    = 32,
  parameter int OP_W      = 5,
  parameter int MD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] inst,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic              flag_eq,
  input  logic              flag_gt,
  output logic [INST_W-1:0] ir,
  output logic [12:0]       alu_op,
  output logic              is_imm,
  output logic              is_ld,
  output logic              is_st,
  output logic              is_call,
  output logic              is_ret,
  output logic              rf_we,
  output logic              flags_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [2:0]        state,
  output logic              trap
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_CYCLES - 1);

  stateT            curState, nxtState;
  decodeT           decNext, decReg;
  logic             illegal;
  logic [CNT_W-1:0] mdCnt;
  logic             mdDone;
  logic             taken;

  simplerisc_decode #(.OP_W(OP_W)) uDecode (
    .opcode  (ir[INST_W-1 -: OP_W]),
    .immBit  (ir[INST_W-OP_W-1]),
    .dec     (decNext),
    .illegal (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState <= FETCH;
      ir       <= '0;
      decReg   <= '0;
      mdCnt    <= '0;
    end else begin
      curState <= nxtState;
      if (curState == FETCH && imem_ack) ir <= inst;
      // down-counter loaded at decode; EXEC ends when it reaches zero
      if (curState == DECODE) begin
        decReg <= decNext;
        mdCnt  <= decNext.isMd ? MD_LAST : '0;
      end else if (curState == EXEC && mdCnt != '0) begin
        mdCnt <= mdCnt - CNT_W'(1);
      end
    end
  end

  assign mdDone = (mdCnt == '0);
  assign taken  = decReg.isB || decReg.isCall || (decReg.isBeq && flag_eq) ||
                  (decReg.isBgt && flag_gt);

  always_comb begin
    nxtState = curState;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    flags_we = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    case (curState)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) nxtState = DECODE;
      end
      DECODE: nxtState = illegal ? TRAP : EXEC;
      EXEC: begin
        if (mdDone) begin
          flags_we = decReg.aluOp[ALU_CMP];
          nxtState = (decReg.isLd || decReg.isSt) ? MEM : WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = decReg.isSt;
        if (dmem_ack) nxtState = WB;
      end
      WB: begin
        rf_we    = decReg.isWb;
        pc_we    = 1'b1;
        if (taken)             pc_sel = 2'd1;
        else if (decReg.isRet) pc_sel = 2'd2;
        nxtState = FETCH;
      end
      TRAP: ;
      default: nxtState = FETCH;
    endcase
  end

  assign alu_op  = decReg.aluOp;
  assign is_imm  = decReg.isImm;
  assign is_ld   = decReg.isLd;
  assign is_st   = decReg.isSt;
  assign is_call = decReg.isCall;
  assign is_ret  = decReg.isRet;
  assign state   = curState;
  assign trap    = (curState == TRAP);

endmodule
